// File: rtl/mulx_seq.sv
// mulx_seq: iterative shift-and-add multiplier, signed or unsigned.
// RADIX_BITS multiplier bits are retired per RUN cycle. Signed operands
// are converted to magnitudes on accept and the sign is reapplied when
// the result is written to p.
module mulx_seq #(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 8,
    parameter int RADIX_BITS = 1,
    parameter int SIGNED_EN  = 1,
    localparam int P_WIDTH   = X_WIDTH + Y_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    output logic [P_WIDTH-1:0] p,
    output logic               s,
    output logic               busy,
    output logic               rdy
);

    // Number of RUN cycles, padded multiplier width and counter width.
    localparam int N_STEPS = (Y_WIDTH + RADIX_BITS - 1) / RADIX_BITS;
    localparam int Y_PAD   = N_STEPS * RADIX_BITS;
    localparam int Y_MAG_W = (Y_PAD > Y_WIDTH + 1) ? Y_PAD : Y_WIDTH + 1;
    localparam int CNT_W   = $clog2(N_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_reg;
    logic [P_WIDTH-1:0]   acc_reg;
    logic [P_WIDTH-1:0]   mcand_reg;
    logic [Y_MAG_W-1:0]   mplier_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 neg_reg;
    logic [P_WIDTH-1:0]   p_reg;
    logic                 s_reg;

    // Operand conditioning: one extra bit so |most negative| is representable.
    logic                 signed_eff;
    logic [X_WIDTH:0]     x_ext;
    logic [X_WIDTH:0]     x_mag;
    logic [Y_WIDTH:0]     y_ext;
    logic [Y_WIDTH:0]     y_mag;
    logic                 neg_next;

    // Magnitudes and result sign of the operands presented with start.
    always_comb begin
        signed_eff = (SIGNED_EN != 0) && signed_mode;
        x_ext      = {signed_eff & x[X_WIDTH-1], x};
        y_ext      = {signed_eff & y[Y_WIDTH-1], y};
        x_mag      = x_ext[X_WIDTH] ? -x_ext : x_ext;
        y_mag      = y_ext[Y_WIDTH] ? -y_ext : y_ext;
        neg_next   = x_ext[X_WIDTH] ^ y_ext[Y_WIDTH];
    end

    // One partial product per multiplier bit of the current digit. The
    // multiplicand register is pre-shifted, so bit gi only adds gi more.
    logic [P_WIDTH-1:0] pp [RADIX_BITS];

    generate
        for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    logic [P_WIDTH-1:0] term;
    logic [P_WIDTH-1:0] acc_sum;
    logic [P_WIDTH-1:0] p_final;

    // Digit contribution, running sum, and sign-corrected final product.
    // Arithmetic is modulo 2^P_WIDTH; the exact result always fits.
    always_comb begin
        term = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            term = term + pp[i];
        end
        acc_sum = acc_reg + term;
        p_final = neg_reg ? -acc_sum : acc_sum;
    end

    // Control FSM and datapath registers; accepts in IDLE or DONE only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            p_reg      <= '0;
            s_reg      <= 1'b0;
        end else if (start && (state_reg != RUN)) begin
            state_reg  <= RUN;
            acc_reg    <= '0;
            mcand_reg  <= P_WIDTH'(x_mag);
            mplier_reg <= Y_MAG_W'(y_mag);
            cnt_reg    <= CNT_W'(N_STEPS);
            neg_reg    <= neg_next;
        end else if (state_reg == RUN) begin
            acc_reg    <= acc_sum;
            mcand_reg  <= mcand_reg << RADIX_BITS;
            mplier_reg <= mplier_reg >> RADIX_BITS;
            cnt_reg    <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
                state_reg <= DONE;
                p_reg     <= p_final;
                s_reg     <= neg_reg && (acc_sum != '0);
            end
        end else begin
            state_reg <= IDLE;
        end
    end

    assign p    = p_reg;
    assign s    = s_reg;
    assign busy = (state_reg == RUN);
    assign rdy  = (state_reg == DONE);

endmodule

// File: doc/mulx_seq.md
# mulx_seq

Parametrised iterative multiplier, successor to the fixed 8x8 unsigned `mulu_m2q2` core. It multiplies an X_WIDTH operand by a Y_WIDTH operand over several clock cycles, retiring RADIX_BITS multiplier bits per cycle, and supports both unsigned and signed (two's-complement) operation. A start/ready handshake lets a shared datapath reuse the block. It is area-optimised for Tiny Tapeout tiles, where a full array multiplier does not fit.

## Interface
Parameters:
- X_WIDTH, 8, multiplicand width (>=2)
- Y_WIDTH, 8, multiplier width (>=2)
- RADIX_BITS, 1, multiplier bits consumed per RUN cycle; legal values 1 or 2
- SIGNED_EN, 1, 1 = signed_mode input is honoured; 0 = the block is always unsigned and s is tied 0
- P_WIDTH (derived, not overridable) = X_WIDTH+Y_WIDTH

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted when state is IDLE or DONE
- signed_mode  input  1  sampled with start; 1 = treat x and y as two's complement
- x  input  X_WIDTH  multiplicand, sampled on the accepted start
- y  input  Y_WIDTH  multiplier, sampled on the accepted start
- p  output  P_WIDTH  product register
- s  output  1  product sign (1 = negative result)
- busy  output  1  high while in RUN
- rdy  output  1  single-cycle pulse: p and s are valid

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch the operands and the mode, clear the accumulator, load the counter with N = ceil(Y_WIDTH/RADIX_BITS), and go to RUN.
- Operand conditioning on accept (signed mode): latch |x| and |y| as unsigned magnitudes one bit wider than the input, so that the most negative value is representable. Latch neg = x_msb XOR y_msb.
- Unsigned mode: neg = 0, and the magnitudes are x and y zero-extended.
- RUN, each cycle:
  - accumulator += (multiplicand magnitude × low RADIX_BITS of the multiplier) << (bit position).
  - Shift the multiplier right by RADIX_BITS and decrement the counter.
  - When the counter reaches 1, the next state is DONE.
  - If Y_WIDTH is not a multiple of RADIX_BITS, the multiplier is zero-extended.
- Entering DONE, in the same edge as the final accumulate:
  - p <= neg ? −acc : acc, truncated to P_WIDTH.
  - s <= neg AND (acc ≠ 0).
- DONE lasts one cycle with rdy=1. Next state:
  - start=1: accept the new operation as in IDLE and go to RUN (back-to-back, no bubble).
  - start=0: go to IDLE.
- p and s hold their values from entering DONE until the next entry into DONE, or until reset. They are not cleared on start.
- start while in RUN is ignored; it is not queued.
- Arithmetic is exact for all inputs. Signed −2^(X−1) × −2^(Y−1) = 2^(P−2) fits in P_WIDTH.

## Timing
- Reset values: state=IDLE, p=0, s=0, busy=0, rdy=0. rst dominates start in the same cycle.
- rst asserted mid-RUN aborts the operation. No rdy pulse is produced and p is cleared to 0.
- Let the accepting edge be E.
  - busy=1 in cycles E+1 … E+N.
  - DONE, with rdy=1, is in cycle E+N+1.
  - Latency from start to rdy = N+1 cycles. Examples:
    - 8x8, RADIX_BITS=1: 9 cycles.
    - 8x8, RADIX_BITS=2: 5 cycles.
    - 8x7, RADIX_BITS=2: N=4, 5 cycles.
- Throughput with start held high: one result every N+1 cycles.
- busy and rdy are never high in the same cycle.
- signed_mode is ignored, and treated as 0, when SIGNED_EN=0.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then start=0 → p=0, s=0, busy=0, rdy=0 held indefinitely.
- Unsigned 8x8, RADIX_BITS=1: x=255, y=255, start for 1 cycle → busy high 8 cycles, rdy at E+9, p=65025 (0xFE01), s=0. p still 0xFE01 10 cycles later.
- Signed 8x8, RADIX_BITS=2:
  - x=−128, y=−128 → p=16384 (0x4000), s=0, rdy at E+5.
  - x=−3, y=5 → p=0xFFF1, s=1.
  - x=−7, y=0 → p=0, s=0.
- Back-to-back: hold start=1 with x=3,y=4 then x=6,y=7, RADIX_BITS=1 → rdy at E+9 with p=12, a new accept in the same cycle, and rdy at E+18 with p=42. A start pulsed mid-RUN has no effect.
- Abort: start x=200,y=100, assert rst at E+4 → no rdy, p=0. A subsequent start x=10,y=10 yields p=100 with normal latency.
- Odd width: X_WIDTH=8, Y_WIDTH=7, RADIX_BITS=2, unsigned x=255, y=127 → rdy at E+5, p=32385.
